// File: rtl/reg_dump_unit.sv
// reg_dump_unit: walks the SR2 read port through R0..R(NUM_REGS-1) and streams
// each value over valid/ready, optionally followed by a 16-bit wrap-around checksum.
module reg_dump_unit #(
    parameter int NUM_REGS = 8,
    parameter bit EMIT_SUM = 1'b1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [2:0]  rf_sel_o,
    input  logic [15:0] rf_data_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [15:0] out_data_o,
    output logic [3:0]  out_idx_o,
    output logic        out_last_o
);
    typedef enum logic [2:0] {IDLE, FETCH, SEND, SUM, DONE} state_t;

    localparam logic [2:0] LAST = 3'(NUM_REGS - 1);

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [15:0] sum_q, sum_d;
    logic        valid_q, valid_d;
    logic [15:0] data_q, data_d;
    logic [3:0]  oidx_q, oidx_d;
    logic        last_q, last_d;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            sum_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            oidx_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            oidx_q  <= oidx_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        valid_d = valid_q;
        data_d  = data_q;
        oidx_d  = oidx_q;
        last_d  = last_q;
        case (state_q)
            IDLE: if (start_i) begin
                state_d = FETCH;
                idx_d   = '0;
                sum_d   = '0;
            end
            FETCH: begin
                data_d  = rf_data_i;
                oidx_d  = {1'b0, idx_q};
                sum_d   = sum_q + rf_data_i;
                valid_d = 1'b1;
                last_d  = (idx_q == LAST) && !EMIT_SUM;
                state_d = SEND;
            end
            SEND: if (out_ready_i) begin
                if (idx_q != LAST) begin
                    idx_d   = idx_q + 3'd1;
                    valid_d = 1'b0;
                    state_d = FETCH;
                end else if (EMIT_SUM) begin
                    // checksum follows the last register with no bubble
                    data_d  = sum_q;
                    oidx_d  = 4'd8;
                    last_d  = 1'b1;
                    state_d = SUM;
                end else begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    state_d = DONE;
                end
            end
            SUM: if (out_ready_i) begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy_o      = state_q != IDLE;
    assign done_o      = state_q == DONE;
    assign rf_sel_o    = (state_q == IDLE) ? 3'd0 : idx_q;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_idx_o   = oidx_q;
    assign out_last_o  = last_q;
endmodule

// File: tb/tb_reg_dump_unit.sv
// tb_reg_dump_unit: directed checks of reg_dump_unit in three configurations
// (8 regs + checksum, 8 regs no checksum, 1 reg no checksum).
module tb_reg_dump_unit;
    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       ready = 1'b1;
    logic [2:0] start = '0;
    wire  [2:0] busy, done, valid, last;
    wire  [2:0] sel [3];
    wire  [15:0] data [3];
    wire  [3:0] oidx [3];
    logic [15:0] rf [8];
    logic [15:0] ex [9];
    int cyc = 0, checks = 0, failures = 0, done_cyc = -1, cur = 0;
    bit collect = 1'b0;

    typedef struct {
        logic [15:0] d;
        logic [3:0]  i;
        logic        l;
        int          c;
    } word_t;
    word_t q[$];

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    reg_dump_unit #(.NUM_REGS(8), .EMIT_SUM(1'b1)) u_a (
        .Clk(Clk), .Reset(Reset), .start_i(start[0]), .busy_o(busy[0]), .done_o(done[0]),
        .rf_sel_o(sel[0]), .rf_data_i(rf[sel[0]]), .out_valid_o(valid[0]), .out_ready_i(ready),
        .out_data_o(data[0]), .out_idx_o(oidx[0]), .out_last_o(last[0]));
    reg_dump_unit #(.NUM_REGS(8), .EMIT_SUM(1'b0)) u_b (
        .Clk(Clk), .Reset(Reset), .start_i(start[1]), .busy_o(busy[1]), .done_o(done[1]),
        .rf_sel_o(sel[1]), .rf_data_i(rf[sel[1]]), .out_valid_o(valid[1]), .out_ready_i(ready),
        .out_data_o(data[1]), .out_idx_o(oidx[1]), .out_last_o(last[1]));
    reg_dump_unit #(.NUM_REGS(1), .EMIT_SUM(1'b0)) u_c (
        .Clk(Clk), .Reset(Reset), .start_i(start[2]), .busy_o(busy[2]), .done_o(done[2]),
        .rf_sel_o(sel[2]), .rf_data_i(rf[sel[2]]), .out_valid_o(valid[2]), .out_ready_i(ready),
        .out_data_o(data[2]), .out_idx_o(oidx[2]), .out_last_o(last[2]));

    // handshake observed mid-cycle completes at the following edge
    always @(negedge Clk) if (collect) begin
        if (valid[cur] && ready) q.push_back('{data[cur], oidx[cur], last[cur], cyc});
        if (done[cur]) done_cyc = cyc;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic base_rf();
        for (int i = 0; i < 8; i++) rf[i] = 16'(i * 16'h1111);
        ex = '{16'h0000, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'hDDDC};
    endtask

    task automatic run(input string tag, input int k, input int n, input bit sum_word,
                       input int stall_at, input int stall_len,
                       input int poke_off, input int poke_reg, input logic [15:0] poke_val);
        int t0, nr, acc;
        bit st;
        q.delete();
        done_cyc = -1;
        cur = k;
        collect = 1'b1;
        t0 = cyc;
        start[k] = 1'b1;
        @(posedge Clk); #1;
        start[k] = 1'b0;
        @(negedge Clk);
        check({tag, "_busy_t1"}, busy[k], 1'b1);
        while (done_cyc < 0 && cyc < t0 + 80) begin
            st = stall_len > 0 && cyc >= t0 + 2 + 2 * stall_at && cyc < t0 + 2 + 2 * stall_at + stall_len;
            ready = !st;
            start[k] = (cyc == t0 + poke_off);
            if (cyc == t0 + poke_off) rf[poke_reg] = poke_val;
            if (st) begin
                @(negedge Clk);
                check({tag, "_stall_data"}, data[k], ex[stall_at]);
                check({tag, "_stall_idx"}, oidx[k], 4'(stall_at));
            end
            @(posedge Clk); #1;
        end
        ready = 1'b1;
        start[k] = 1'b0;
        collect = 1'b0;
        nr = sum_word ? n - 1 : n;
        check({tag, "_count"}, q.size(), n);
        acc = 0;
        for (int i = 0; i < n && i < q.size(); i++) begin
            acc = (i < nr) ? t0 + 2 + 2 * i + ((stall_len > 0 && i >= stall_at) ? stall_len : 0) : acc + 1;
            check($sformatf("%s_w%0d_data", tag, i), q[i].d, ex[i]);
            check($sformatf("%s_w%0d_idx", tag, i), q[i].i, (i < nr) ? i : 8);
            check($sformatf("%s_w%0d_last", tag, i), q[i].l, i == n - 1);
            check($sformatf("%s_w%0d_cyc", tag, i), q[i].c - t0, acc - t0);
        end
        check({tag, "_done_cyc"}, done_cyc - t0, acc + 1 - t0);
        @(negedge Clk);
        check({tag, "_idle_busy"}, busy[k], 1'b0);
        @(posedge Clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, valid[0], 1'b0);
        check({tag, "_data"}, data[0], 16'h0);
        check({tag, "_idx"}, oidx[0], 4'h0);
        check({tag, "_last"}, last[0], 1'b0);
        check({tag, "_busy_done"}, {busy[0], done[0]}, 2'b00);
        check({tag, "_sel"}, sel[0], 3'd0);
    endtask

    initial begin
        int t0;
        base_rf();
        repeat (2) @(posedge Clk);
        #1;
        @(negedge Clk);
        check_reset_outputs("rst");
        @(posedge Clk); #1;
        Reset = 1'b0;
        @(posedge Clk); #1;

        base_rf();
        run("full", 0, 9, 1'b1, 0, 0, -1, 0, 16'h0);

        base_rf();
        run("bp", 0, 9, 1'b1, 3, 5, 9, 3, 16'hAAAA);

        for (int i = 0; i < 8; i++) rf[i] = 16'hFFFF;
        ex = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFF8};
        run("wrapf", 0, 9, 1'b1, 0, 0, -1, 0, 16'h0);

        for (int i = 0; i < 8; i++) rf[i] = 16'h0;
        rf[0] = 16'h8000;
        rf[1] = 16'h8000;
        ex = '{16'h8000, 16'h8000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0000};
        run("wrap8", 0, 9, 1'b1, 0, 0, -1, 0, 16'h0);

        base_rf();
        ex[5] = 16'hBEEF;
        ex[8] = 16'h4776;
        run("wr", 0, 9, 1'b1, 0, 0, 6, 5, 16'hBEEF);

        base_rf();
        t0 = cyc;
        start[0] = 1'b1;
        @(posedge Clk); #1;
        start[0] = 1'b0;
        while (cyc < t0 + 6) begin
            @(posedge Clk); #1;
        end
        Reset = 1'b1;
        @(negedge Clk);
        check("midrst_pre_valid", valid[0], 1'b1);
        @(posedge Clk); #1;
        @(negedge Clk);
        check_reset_outputs("midrst");
        @(posedge Clk); #1;
        Reset = 1'b0;
        run("fresh", 0, 9, 1'b1, 0, 0, -1, 0, 16'h0);

        base_rf();
        run("nosum", 1, 8, 1'b0, 0, 0, -1, 0, 16'h0);

        base_rf();
        rf[0] = 16'h1234;
        ex[0] = 16'h1234;
        run("one", 2, 1, 1'b0, 0, 0, -1, 0, 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
